// File: rtl/t2mi_plp_packet_arbiter_if.sv
// Byte-stream bundle between the packet sources and the T2-MI arbiter.
// master = arbiter side, slave = source side.
interface t2mi_plp_packet_arbiter_if;
  logic [2:0] req;
  logic [2:0] ena_in;
  logic [2:0] last_in;
  logic [7:0] data0;
  logic [7:0] data1;
  logic [7:0] data2;
  logic [2:0] gnt;
  logic [7:0] data_out;
  logic       ena_out;

  modport master (
    input  req, ena_in, last_in,
    input  data0, data1, data2,
    output gnt, data_out, ena_out
  );

  modport slave (
    output req, ena_in, last_in,
    output data0, data1, data2,
    input  gnt, data_out, ena_out
  );
endinterface

// File: rtl/t2mi_plp_packet_arbiter.sv
// Packet-atomic arbiter for PLP0, PLP1 and signalling sources.
// Fixed T2-frame schedule W0/W1/2 packets with frame/superframe index.
module t2mi_plp_packet_arbiter #(
  parameter int TIMEOUT_CYC = 4096,
  parameter int TO_W        = 13
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [9:0]  w0,
  input  logic [9:0]  w1,
  input  logic [7:0]  num_t2_frames,
  input  logic        err_clr,
  output logic        frame_start,
  output logic [7:0]  frame_idx,
  output logic [3:0]  superframe_idx,
  output logic        timeout_err,
  output logic [1:0]  state_mon,
  t2mi_plp_packet_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    XFER = 2'd2,
    NEXT = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  slot_q, slot_d;
  logic [9:0]  pkt_q, pkt_d;
  logic [9:0]  q0_q, q0_d;
  logic [9:0]  q1_q, q1_d;
  logic [TO_W-1:0] to_q, to_d;
  logic [2:0]  gnt_q, gnt_d;
  logic [7:0]  dout_q, dout_d;
  logic        eout_q, eout_d;
  logic        fs_q, fs_d;
  logic [7:0]  fidx_q, fidx_d;
  logic [3:0]  sfidx_q, sfidx_d;
  logic        err_q, err_d;

  logic [9:0]  quota;
  logic [7:0]  fr_last;
  logic        s_req, s_ena, s_last;
  logic [7:0]  s_data;

  always_comb begin
    s_req  = 1'b0;
    s_ena  = 1'b0;
    s_last = 1'b0;
    s_data = 8'd0;
    quota  = 10'd2;
    case (slot_q)
      2'd0: begin
        s_req  = bus.req[0];
        s_ena  = bus.ena_in[0];
        s_last = bus.last_in[0];
        s_data = bus.data0;
        quota  = q0_q;
      end
      2'd1: begin
        s_req  = bus.req[1];
        s_ena  = bus.ena_in[1];
        s_last = bus.last_in[1];
        s_data = bus.data1;
        quota  = q1_q;
      end
      default: begin
        s_req  = bus.req[2];
        s_ena  = bus.ena_in[2];
        s_last = bus.last_in[2];
        s_data = bus.data2;
      end
    endcase
    fr_last = (num_t2_frames == 8'd0) ? 8'd0
            : num_t2_frames - 8'd1;
  end

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    pkt_d   = pkt_q;
    q0_d    = q0_q;
    q1_d    = q1_q;
    to_d    = to_q;
    gnt_d   = gnt_q;
    dout_d  = dout_q;
    eout_d  = 1'b0;
    fs_d    = 1'b0;
    fidx_d  = fidx_q;
    sfidx_d = sfidx_q;
    err_d   = err_q & ~err_clr;
    unique case (state_q)
      IDLE: begin
        gnt_d = 3'b000;
        if (enable) begin
          q0_d    = w0;
          q1_d    = w1;
          slot_d  = 2'd0;
          pkt_d   = 10'd0;
          fs_d    = 1'b1;
          state_d = NEXT;
        end
      end
      NEXT: begin
        if (pkt_q != quota) begin
          to_d    = '0;
          state_d = WAIT;
        end else if (slot_q != 2'd2) begin
          slot_d = slot_q + 2'd1;
          pkt_d  = 10'd0;
        end else begin
          // end of T2 frame: advance indices, reload quotas
          slot_d = 2'd0;
          pkt_d  = 10'd0;
          q0_d   = w0;
          q1_d   = w1;
          if (fidx_q >= fr_last) begin
            fidx_d  = 8'd0;
            sfidx_d = sfidx_q + 4'd1;
          end else begin
            fidx_d = fidx_q + 8'd1;
          end
          if (enable) fs_d = 1'b1;
          else state_d = IDLE;
        end
      end
      WAIT: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (s_req) begin
          gnt_d   = 3'b001 << slot_q;
          state_d = XFER;
        end else begin
          to_d = to_q + 1'b1;
          if (to_d == TO_W'(TIMEOUT_CYC)) begin
            err_d   = 1'b1;
            pkt_d   = quota;
            state_d = NEXT;
          end
        end
      end
      XFER: begin
        dout_d = s_data;
        eout_d = s_ena;
        if (s_ena && s_last) begin
          gnt_d   = 3'b000;
          pkt_d   = pkt_q + 10'd1;
          state_d = enable ? NEXT : IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      slot_q  <= 2'd0;
      pkt_q   <= 10'd0;
      q0_q    <= 10'd0;
      q1_q    <= 10'd0;
      to_q    <= '0;
      gnt_q   <= 3'b000;
      dout_q  <= 8'd0;
      eout_q  <= 1'b0;
      fs_q    <= 1'b0;
      fidx_q  <= 8'd0;
      sfidx_q <= 4'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      pkt_q   <= pkt_d;
      q0_q    <= q0_d;
      q1_q    <= q1_d;
      to_q    <= to_d;
      gnt_q   <= gnt_d;
      dout_q  <= dout_d;
      eout_q  <= eout_d;
      fs_q    <= fs_d;
      fidx_q  <= fidx_d;
      sfidx_q <= sfidx_d;
      err_q   <= err_d;
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.data_out   = dout_q;
  assign bus.ena_out    = eout_q;
  assign frame_start    = fs_q;
  assign frame_idx      = fidx_q;
  assign superframe_idx = sfidx_q;
  assign timeout_err    = err_q;
  assign state_mon      = state_q;

endmodule
